// File: rtl/lightcube_pkg.sv
// Shared definitions for the light-cube UART frame loader: receiver state encoding,
// parity-mode constants and the elaboration-time sizing helpers.
package lightcube_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // One bit per voxel, packed eight voxels to a byte.
  function automatic int frame_bytes(input int cube_n);
    return (cube_n * cube_n * cube_n) / 8;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: rx synchroniser, baud counter and bit FSM producing single-cycle
// byte/error strobes. Parity enforcement is compiled in with UART_PARITY_CHECK_EN.
module uart_rx_core
  import lightcube_pkg::*;
#(
  parameter int BAUD_DIV    = 868,
  parameter int PARITY_MODE = PARITY_EVEN
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       rx,
  output logic       idle,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       parity_err,
  output logic       stop_err
);

  localparam int            CW        = clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta, rx_sync, rx_prev;
  logic          parity_bad;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (!enable) begin
        state_q <= RX_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        bit_idx_q <= bit_idx_d;
        shift_q   <= shift_d;
      end
    end
  end

`ifdef UART_PARITY_CHECK_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      par_q <= 1'b0;
    end else if (enable && state_q == RX_PARITY && cnt_q == BIT_LAST) begin
      par_q <= rx_sync;
    end
  end

  assign parity_bad = (PARITY_MODE != PARITY_NONE) &&
                      (par_q != ((^shift_q) ^ (PARITY_MODE == PARITY_ODD)));
`else
  assign parity_bad = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    parity_err = 1'b0;
    stop_err   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = RX_IDLE;
            if (parity_bad) parity_err = 1'b1;
            else            byte_valid = 1'b1;
          end else begin
            stop_err = 1'b1;
            state_d  = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign idle      = (state_q == RX_IDLE);
  assign byte_data = shift_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Light-cube frame loader: assembles received bytes into a double-buffered voxel frame and
// swaps halves on completion. Optional parity enforcement: define UART_PARITY_CHECK_EN.
module uart_frame_loader
  import lightcube_pkg::*;
#(
  parameter int  BAUD_DIV    = 868,
  parameter int  CUBE_N      = 8,
  parameter int  PARITY_MODE = PARITY_EVEN,
  parameter int  GAP_TIMEOUT = 13020,
  localparam int FRAME_BYTES = frame_bytes(CUBE_N),
  localparam int AW          = clog2(FRAME_BYTES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          rx,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_valid,
  output logic          frame_done,
  output logic [AW:0]   byte_cnt,
  output logic          err_parity,
  output logic          err_stop,
  output logic          err_gap
);

  localparam int            GW       = clog2(GAP_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_FULL = (AW + 1)'(FRAME_BYTES);
  localparam logic [AW:0]   PTR_LAST = (AW + 1)'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  logic          rx_idle, byte_valid, parity_err, stop_err;
  logic [7:0]    byte_data;
  logic [AW:0]   wr_ptr;
  logic [GW-1:0] gap_cnt;
  logic          front_sel;
  logic          swap, accept, gap_hit, rd_sel, frame_valid_next;
  logic [7:0]    mem [2*FRAME_BYTES];

  uart_rx_core #(
    .BAUD_DIV    (BAUD_DIV),
    .PARITY_MODE (PARITY_MODE)
  ) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .rx         (rx),
    .idle       (rx_idle),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .parity_err (parity_err),
    .stop_err   (stop_err)
  );

  // wr_ptr sits at FRAME_BYTES for exactly one cycle, which is the swap cycle.
  // A last byte landing as enable falls still completes its frame.
  assign swap    = (wr_ptr == PTR_FULL);
  assign accept  = byte_valid && (enable || wr_ptr == PTR_LAST);
  assign gap_hit = enable && rx_idle && (wr_ptr != '0) && (gap_cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      gap_cnt     <= '0;
      front_sel   <= 1'b0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      err_parity  <= 1'b0;
      err_stop    <= 1'b0;
      err_gap     <= 1'b0;
    end else begin
      frame_done <= swap;
      err_parity <= enable && parity_err;
      err_stop   <= enable && stop_err;
      err_gap    <= gap_hit;
      if (swap) begin
        front_sel   <= ~front_sel;
        frame_valid <= 1'b1;
      end
      if (swap)                                             wr_ptr <= '0;
      else if (accept)                                      wr_ptr <= wr_ptr + 1'b1;
      else if (!enable || parity_err || stop_err || gap_hit) wr_ptr <= '0;
      if (!enable || !rx_idle || wr_ptr == '0 || gap_hit) gap_cnt <= '0;
      else                                                gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // NOTE: the frame RAM is deliberately not reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (accept) mem[{~front_sel, wr_ptr[AW-1:0]}] <= byte_data;
  end

  // The read uses the post-swap select so the swap cycle already shows the new front.
  assign rd_sel           = front_sel ^ swap;
  assign frame_valid_next = frame_valid | swap;

  always_ff @(posedge clk) begin
    if (!resetn)               rd_data <= '0;
    else if (frame_valid_next) rd_data <= mem[{rd_sel, rd_addr}];
    else                       rd_data <= '0;
  end

  assign byte_cnt = wr_ptr;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: queue-based frame model, a table of
// error/resync vectors, hand-written corner sequences and a randomized byte stream.
module tb_uart_frame_loader;

  localparam int BAUD_DIV    = 8;
  localparam int CUBE_N      = 8;
  localparam int PARITY_MODE = 1;
  localparam int GAP_TIMEOUT = 120;
  localparam int FB          = 64;
  localparam int AW          = 6;
`ifdef UART_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b1;
  logic          rx     = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_valid, frame_done, err_parity, err_stop, err_gap;
  logic [AW:0]   byte_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0, n_par = 0, n_stop = 0, n_gap = 0, max_cnt = 0;
  int exp_done = 0, exp_par = 0, exp_stop = 0, exp_gap = 0;

  logic [7:0] model_front [FB];
  logic [7:0] model_back  [$];
  bit         model_valid = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         par_bad;
    bit         stop_bad;
    int         idle_bits;
    int         exp_cnt;
    int         exp_stop;
    int         exp_par;
    int         exp_gap;
  } vec_t;

  vec_t vecs [10];

  uart_frame_loader #(
    .BAUD_DIV    (BAUD_DIV),
    .CUBE_N      (CUBE_N),
    .PARITY_MODE (PARITY_MODE),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .rx          (rx),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .byte_cnt    (byte_cnt),
    .err_parity  (err_parity),
    .err_stop    (err_stop),
    .err_gap     (err_gap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done) n_done++;
      if (err_parity) n_par++;
      if (err_stop)   n_stop++;
      if (err_gap)    n_gap++;
      if (int'(byte_cnt) > max_cnt) max_cnt = int'(byte_cnt);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit pb, input bit sb, input int idle_bits);
    logic p;
    p = (^b) ^ (PARITY_MODE == 2) ^ pb;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PARITY_MODE != 0) drive_bit(p);
    drive_bit(!sb);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
  endtask

  // Frame-level behaviour: bytes append to the back frame; errors and long gaps discard it.
  task automatic send(input logic [7:0] b, input bit pb, input bit sb, input int idle_bits);
    tx_byte(b, pb, sb, idle_bits);
    if (sb) begin
      exp_stop++;
      model_back.delete();
    end else if (pb && PCHK) begin
      exp_par++;
      model_back.delete();
    end else begin
      model_back.push_back(b);
      if (model_back.size() == FB) begin
        for (int i = 0; i < FB; i++) model_front[i] = model_back[i];
        model_valid = 1'b1;
        exp_done++;
        model_back.delete();
      end
    end
    if (idle_bits >= 15 && model_back.size() > 0) begin
      exp_gap++;
      model_back.delete();
    end
  endtask

  task automatic check_front(input string tag);
    logic [7:0] expv;
    for (int a = 0; a < FB; a++) begin
      rd_addr = AW'(a);
      @(negedge clk);
      expv = model_valid ? model_front[a] : 8'h00;
      check($sformatf("%s rd[%0d]", tag, a), rd_data, expv);
    end
  endtask

  task automatic read_one(input int a, output logic [7:0] d);
    rd_addr = AW'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " frame_done count"}, n_done, exp_done);
    check({tag, " err_parity count"}, n_par, exp_par);
    check({tag, " err_stop count"}, n_stop, exp_stop);
    check({tag, " err_gap count"}, n_gap, exp_gap);
    check({tag, " frame_valid"}, frame_valid, model_valid);
    check({tag, " byte_cnt"}, byte_cnt, model_back.size());
  endtask

  initial begin
    logic [7:0] d;
    int base_done, base_par, base_stop, base_gap;

    vecs[0] = '{8'h11, 1'b0, 1'b0, 2,  1, 0, 0, 0};
    vecs[1] = '{8'h22, 1'b0, 1'b0, 2,  2, 0, 0, 0};
    vecs[2] = '{8'h33, 1'b0, 1'b0, 2,  3, 0, 0, 0};
    vecs[3] = '{8'h44, 1'b0, 1'b1, 2,  0, 1, 0, 0};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 2,  1, 0, 0, 0};
    vecs[5] = '{8'h66, 1'b1, 1'b0, 2,  PCHK ? 0 : 2, 0, PCHK ? 1 : 0, 0};
    vecs[6] = '{8'h77, 1'b0, 1'b0, 2,  PCHK ? 1 : 3, 0, 0, 0};
    vecs[7] = '{8'h88, 1'b0, 1'b0, 20, 0, 0, 0, 1};
    vecs[8] = '{8'h99, 1'b0, 1'b0, 2,  1, 0, 0, 0};
    vecs[9] = '{8'hAA, 1'b0, 1'b0, 2,  2, 0, 0, 0};
    for (int i = 0; i < FB; i++) model_front[i] = 8'h00;

    repeat (4) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset frame_done", frame_done, 1'b0);
    check("reset byte_cnt", byte_cnt, 0);
    check("reset err_parity", err_parity, 1'b0);
    check("reset err_stop", err_stop, 1'b0);
    check("reset err_gap", err_gap, 1'b0);
    check_front("reset");

    // Two frames of i^j, 10 bit times idle between bytes
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < FB; i++) send(8'(i ^ j), 1'b0, 1'b0, 10);
      check($sformatf("frame%0d frame_done count", j), n_done, j + 1);
      read_one(5, d);
      check($sformatf("frame%0d rd[5]", j), d, j == 0 ? 8'h05 : 8'h04);
      check_front($sformatf("frame%0d", j));
      check_counts($sformatf("frame%0d", j));
    end

    // Parity corruption on byte 10, then a clean random frame
    base_par = n_par;
    for (int i = 0; i < 10; i++) send(8'(8'hA0 + i), 1'b0, 1'b0, 2);
    send(8'hAA, 1'b1, 1'b0, 2);
    check("parity byte_cnt", byte_cnt, PCHK ? 0 : 11);
    for (int i = 0; i < FB; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    check("parity err_parity pulses", n_par - base_par, PCHK ? 1 : 0);
    check_front("parity");
    check_counts("parity");

    // Gap resync: 30 bytes, 20 bit times idle, then a full frame
    base_gap = n_gap;
    for (int i = 0; i < 30; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, i == 29 ? 20 : 2);
    check("gap byte_cnt", byte_cnt, 0);
    for (int i = 0; i < FB; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    check("gap err_gap pulses", n_gap - base_gap, 1);
    check_front("gap");
    check_counts("gap");

    // Table of error/resync vectors
    for (int v = 0; v < 10; v++) begin
      base_stop = n_stop;
      base_par  = n_par;
      base_gap  = n_gap;
      send(vecs[v].data, vecs[v].par_bad, vecs[v].stop_bad, vecs[v].idle_bits);
      check($sformatf("vec%0d byte_cnt", v), byte_cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d err_stop", v), n_stop - base_stop, vecs[v].exp_stop);
      check($sformatf("vec%0d err_parity", v), n_par - base_par, vecs[v].exp_par);
      check($sformatf("vec%0d err_gap", v), n_gap - base_gap, vecs[v].exp_gap);
    end

    // Two-cycle low glitch: no byte and no error
    base_stop = n_stop;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BAUD_DIV) @(negedge clk);
    check("glitch byte_cnt", byte_cnt, 2);
    check("glitch err_stop", n_stop - base_stop, 0);
    check_counts("glitch");

    // Enable dropped mid-frame
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    check("pre-disable byte_cnt", byte_cnt, 5);
    enable = 1'b0;
    model_back.delete();
    repeat (4) @(negedge clk);
    check("disabled byte_cnt", byte_cnt, 0);
    base_done = n_done;
    tx_byte(8'h5A, 1'b0, 1'b1, 2);
    check("disabled byte_cnt after traffic", byte_cnt, 0);
    check("disabled frame_done", n_done - base_done, 0);
    check_counts("disabled");
    check_front("disabled");
    enable = 1'b1;
    repeat (2 * BAUD_DIV) @(negedge clk);
    for (int i = 0; i < FB / 2; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    check("reenabled half byte_cnt", byte_cnt, FB / 2);
    check_front("reenabled half");
    for (int i = 0; i < FB / 2; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    check_front("reenabled full");
    check_counts("reenabled");

    // Randomized stream with occasional framing and parity errors
    for (int n = 0; n < 100; n++) begin
      int r;
      r = $urandom_range(0, 19);
      send(8'($urandom_range(0, 255)), r == 1, r == 0, $urandom_range(1, 10));
      check($sformatf("random%0d byte_cnt", n), byte_cnt, model_back.size());
    end
    check_counts("random");
    check_front("random");
    check("byte_cnt peak", max_cnt, FB);

    // Reset mid-frame discards the partial frame and the front buffer view
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_back.delete();
    model_valid = 1'b0;
    @(negedge clk);
    check("post-reset frame_valid", frame_valid, 1'b0);
    check("post-reset byte_cnt", byte_cnt, 0);
    read_one(5, d);
    check("post-reset rd[5]", d, 8'h00);
    send(8'h3C, 1'b0, 1'b0, 2);
    check("post-reset first byte_cnt", byte_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
